// File: rtl/uart_tx_ctrl.sv
// UART frame serializer: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// States: IDLE (line 1) | START (0) | DATA (shift_reg[0]) | PARITY (parity) | STOP (1).
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Data_Valid,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             PAR_EN,
  input  logic             parity,
  output logic             TX_OUT,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic             par_en_q;

  // TX_OUT and busy are loaded with the values of the state being entered,
  // so each line bit appears on the same edge the FSM moves into its slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          if (Data_Valid) begin
            shift_reg <= P_DATA;
            par_en_q  <= PAR_EN;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          TX_OUT    <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= '0;
          state     <= DATA;
        end
        DATA: begin
          if (bit_cnt == CW'(WIDTH - 1)) begin
            if (par_en_q) begin
              TX_OUT <= parity;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            TX_OUT    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + CW'(1);
          end
        end
        PARITY: begin
          TX_OUT <= 1'b1;
          state  <= STOP;
        end
        STOP: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues per-cycle line/busy expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Data_Valid = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       PAR_EN = 1'b0;
  logic       parity = 1'b0;
  logic       TX_OUT;
  logic       busy;

  uart_tx_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .PAR_EN(PAR_EN), .parity(parity), .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    cyc;
    logic  tx;
    logic  bsy;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // One cycle of stimulus; the expectation targets the output after the next posedge.
  task automatic step(input logic dv, input logic [7:0] d, input logic pe, input logic par,
                      input logic rst, input logic etx, input logic ebusy, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    Data_Valid = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    parity     = par;
    RST        = rst;
    e.cyc = cyc + 1;
    e.tx  = etx;
    e.bsy = ebusy;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // seq lists the line bits in transmit order, leftmost first.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic par,
                           input logic [10:0] seq, input int len,
                           input int glitch_at, input int rst_at, input string tag);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        step(1'b0, ~d, ~pe, par, 1'b1, 1'b1, 1'b0, {tag, "_rst"});
        step(1'b0, ~d, ~pe, par, 1'b0, 1'b1, 1'b0, {tag, "_rst_idle"});
        return;
      end
      if (i == 0)
        step(1'b1, d, pe, par, 1'b0, seq[len-1-i], 1'b1, tag);
      else if (i == glitch_at)
        step(1'b1, 8'hFF, 1'b1, par, 1'b0, seq[len-1-i], 1'b1, {tag, "_glitch"});
      else
        step(1'b0, ~d, ~pe, par, 1'b0, seq[len-1-i], 1'b1, tag);
    end
    step(1'b0, ~d, 1'b0, par, 1'b0, 1'b1, 1'b0, {tag, "_idle"});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.cyc != cyc) begin
          miscompares++;
          $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", e.tag, e.cyc, cyc);
        end else if (TX_OUT !== e.tx || busy !== e.bsy) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got TX_OUT=%b busy=%b, required TX_OUT=%b busy=%b",
                   e.tag, cyc, TX_OUT, busy, e.tx, e.bsy);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "reset");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "reset");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "idle");

    run_frame(8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, -1, -1, "par_a5");
    run_frame(8'h3C, 1'b0, 1'b0, 11'b00001111001, 10, -1, -1, "nopar_3c");

    run_frame(8'h00, 1'b0, 1'b0, 11'b00000000001, 10, 4, -1, "ignore_00");
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ignore_after");

    run_frame(8'h01, 1'b0, 1'b0, 11'b00100000001, 10, -1, -1, "b2b_01");
    run_frame(8'h80, 1'b0, 1'b0, 11'b00000000011, 10, -1, -1, "b2b_80");

    run_frame(8'h0F, 1'b0, 1'b0, 11'b00111100001, 10, -1, 5, "rst_mid_0f");
    run_frame(8'hC3, 1'b1, 1'b1, 11'b01100001111, 11, -1, -1, "after_rst_c3");

    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "rst_prio");
    for (int i = 0; i < 4; i++)
      step(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_prio_idle");

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge CLK);
      waited++;
    end
    @(posedge CLK);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer and serializer for the UART transmitter. It accepts a parallel byte on a `Data_Valid` strobe and drives the `TX_OUT` line one bit per `CLK` cycle: start bit, data bits LSB first, an optional parity bit, then a stop bit. The parity bit is taken from the `parity_calc` output. This block is the controller between the parallel data source and the TX line.

## Interface

- `WIDTH`, default 8: data bits per frame; must be ≥ 2.

- `CLK` input 1: single clock; one TX bit per cycle.
- `RST` input 1: one clock; reset is synchronous and active-high.
- `Data_Valid` input 1: frame request strobe; `P_DATA` is valid in the same cycle.
- `P_DATA` input WIDTH: parallel data to transmit.
- `PAR_EN` input 1: parity enable; sampled with `Data_Valid`.
- `parity` input 1: parity bit from `parity_calc`.
- `TX_OUT` output 1: serial line; registered; idle level 1.
- `busy` output 1: registered; high while a frame occupies the line.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `TX_OUT`=1, `busy`=0.
  - When `Data_Valid`=1, latch `P_DATA` into the shift register, latch `PAR_EN`, and go to START.
- **START:** `TX_OUT`=0, `busy`=1. Clear `bit_cnt`, then go to DATA.
- **DATA:** `TX_OUT`=shift_reg[0]. Shift right each cycle and increment `bit_cnt` (width `$clog2(WIDTH)`).
  - Leave after exactly WIDTH cycles, when `bit_cnt`==WIDTH-1.
  - Go to PARITY if the latched `PAR_EN`=1, else go to STOP.
- **PARITY:** `TX_OUT`=`parity`, captured on the last DATA cycle. Go to STOP.
- **STOP:** `TX_OUT`=1, `busy`=1. Go to IDLE unconditionally.
- `Data_Valid` is accepted only in IDLE. It is ignored in all other states and does not alter the latched data or `PAR_EN`.
- Upstream must not pulse `Data_Valid` while `busy`=1. If it does, `parity_calc` re-latches its data and the transmitted parity bit is undefined. This block still sends its originally latched data bits.
- `PAR_EN` changes after acceptance have no effect on the frame in flight.
- Frame length in cycles with `busy`=1 is 1 + WIDTH + `PAR_EN` + 1. For WIDTH=8 this is 11 with parity and 10 without.
- **Reset** (priority over `Data_Valid`):
  - Values: state=IDLE, `TX_OUT`=1, `busy`=0, shift register=0, `bit_cnt`=0, latched `PAR_EN`=0.
  - A reset asserted mid-frame abandons the frame immediately. The line returns to 1 on the next edge, with no stop bit and no partial frame completion.

## Timing

- `Data_Valid` high in IDLE at edge N:
  - START (`TX_OUT`=0, `busy`=1) is visible after edge N+1.
  - Data bit k is visible after edge N+2+k.
- Parity bit is visible after edge N+2+WIDTH.
- Stop bit is visible after edge N+2+WIDTH+`PAR_EN`.
- `busy` falls after the stop-bit cycle.
- The earliest next accept is the first cycle with `busy`=0. That gives one idle bit minimum between frames, and the idle cycle shows `TX_OUT`=1.
- `parity_calc` settles 2 cycles after `Data_Valid`. It is sampled on the last DATA cycle (≥ cycle N+1+WIDTH), so it is always settled.
- All outputs are registered. There is no combinational path from inputs to `TX_OUT` or `busy`.

## Test plan

- **Parity frame:** reset, then `Data_Valid` with `P_DATA`=0xA5, `PAR_EN`=1, even parity (`parity`=0).
  - Required `TX_OUT` sequence: 0,1,0,1,0,0,1,0,1,0,1.
  - `busy` high for exactly 11 cycles, then 0.
- **No-parity frame:** `P_DATA`=0x3C, `PAR_EN`=0.
  - Required `TX_OUT` sequence: 0,0,0,1,1,1,1,0,0,1.
  - `busy` high for exactly 10 cycles; no parity slot.
- **Ignored strobe:** pulse `Data_Valid` with `P_DATA`=0xFF mid-DATA of a 0x00 frame with `PAR_EN`=0 and `parity` held at 0 by the bench.
  - All 8 data bits stay 0 and the frame length is unchanged.
  - No second frame follows; `TX_OUT` stays 1 after STOP.
- **Back-to-back:** assert `Data_Valid` (0x01, then 0x80, `PAR_EN`=0) on the first cycle `busy`=0.
  - Exactly one idle 1 bit between frames.
  - Second frame data reads 0,0,0,0,0,0,0,1.
- **Reset mid-frame:** assert `RST` during data bit 3.
  - Next cycle `TX_OUT`=1, `busy`=0.
  - A new `Data_Valid` afterwards produces a complete, correct frame.
- **Reset priority:** `RST`=1 and `Data_Valid`=1 in the same cycle.
  - Block stays IDLE and no frame starts.
